// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the convolution front end
package cnn_pkg;
  localparam int KERNEL_SIZE = 3;
  localparam int DATA_WIDTH = 16;
  typedef logic signed [DATA_WIDTH-1:0] pixel_t;
  typedef enum logic [2:0] {IDLE, K_RX, K_TX, PIX, FLUSH, DONE} feeder_state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of storage, read-before-write at a single address
module conv_line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  // store the new value; the old value remains on rdata until this edge
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
endmodule

// File: rtl/conv_column_feeder.sv
// conv_column_feeder: turns a kernel stream and a raster pixel stream into three-lane engine beats
module conv_column_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reuse_kernel,
  input  logic [DATA_WIDTH-1:0] kernel_in,
  input  logic                  kernel_valid,
  output logic                  kernel_ready,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] conv_data0,
  output logic [DATA_WIDTH-1:0] conv_data1,
  output logic [DATA_WIDTH-1:0] conv_data2,
  output logic                  conv_kernel_load,
  output logic                  conv_valid_in,
  output logic                  conv_valid_out,
  output logic                  busy,
  output logic                  frame_done
);
  import cnn_pkg::*;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  if (KERNEL_SIZE != cnn_pkg::KERNEL_SIZE || IMG_WIDTH < 4 || IMG_HEIGHT < 3) begin : g_bad_params
    $error("conv_column_feeder: only a 3x3 kernel and images of at least 4x3 are supported");
  end
  feeder_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0] kcnt;
  logic kernel_loaded;
  logic [DATA_WIDTH-1:0] w [KERNEL_SIZE*KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] row1, row2;
  logic pix_take;
  assign kernel_ready = state == K_RX;
  assign pix_ready = state == PIX;
  assign busy = state != IDLE;
  assign pix_take = pix_ready && pix_valid;
  // row y-1 lives in lb1; its displaced value shifts into lb2 as row y-2
  conv_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .we(pix_take), .addr(x), .wdata(pix_in), .rdata(row1)
  );
  conv_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
    .clk(clk), .we(pix_take), .addr(x), .wdata(row1), .rdata(row2)
  );
  // weight capture in row-major order
  always_ff @(posedge clk) if (kernel_ready && kernel_valid) w[kcnt] <= kernel_in;
  // frame sequencing and registered engine beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      kcnt <= '0;
      kernel_loaded <= 1'b0;
      conv_data0 <= '0;
      conv_data1 <= '0;
      conv_data2 <= '0;
      conv_kernel_load <= 1'b0;
      conv_valid_in <= 1'b0;
      conv_valid_out <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      conv_kernel_load <= 1'b0;
      conv_valid_in <= 1'b0;
      conv_valid_out <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x <= '0;
          y <= '0;
          kcnt <= '0;
          state <= (reuse_kernel && kernel_loaded) ? PIX : K_RX;
        end
        K_RX: if (kernel_valid) begin
          kcnt <= (kcnt == 4'd8) ? 4'd0 : kcnt + 4'd1;
          if (kcnt == 4'd8) begin
            kernel_loaded <= 1'b1;
            state <= K_TX;
          end
        end
        K_TX: begin
          conv_data0 <= w[kcnt];
          conv_data1 <= w[kcnt + 4'd3];
          conv_data2 <= w[kcnt + 4'd6];
          conv_kernel_load <= 1'b1;
          conv_valid_in <= 1'b1;
          kcnt <= (kcnt == 4'd2) ? 4'd0 : kcnt + 4'd1;
          if (kcnt == 4'd2) state <= PIX;
        end
        PIX: if (pix_valid) begin
          if (y >= YW'(2)) begin
            conv_data0 <= row2;
            conv_data1 <= row1;
            conv_data2 <= pix_in;
            conv_valid_in <= 1'b1;
            conv_valid_out <= x >= XW'(3);
          end
          x <= (x == X_LAST) ? '0 : x + XW'(1);
          if (x == X_LAST && y >= YW'(2)) state <= FLUSH;
          if (x == X_LAST && y < YW'(2)) y <= y + YW'(1);
        end
        FLUSH: begin
          conv_data0 <= '0;
          conv_data1 <= '0;
          conv_data2 <= '0;
          conv_valid_in <= 1'b1;
          conv_valid_out <= 1'b1;
          frame_done <= y == Y_LAST;
          y <= (y == Y_LAST) ? y : y + YW'(1);
          state <= (y == Y_LAST) ? DONE : PIX;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_column_feeder.sv
// tb_conv_column_feeder: scoreboard bench for a 4x3 and a 28x28 feeder
module tb_conv_column_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0, start_b = 1'b0, reuse_kernel = 1'b0;
  logic [15:0] kernel_in = '0, pix_in = '0;
  logic kernel_valid = 1'b0, pix_valid = 1'b0;
  logic s_kernel_ready, s_pix_ready, s_kl, s_vi, s_vo, s_busy, s_fd;
  logic [15:0] s_d0, s_d1, s_d2;
  logic b_kernel_ready, b_pix_ready, b_kl, b_vi, b_vo, b_busy, b_fd;
  logic [15:0] b_d0, b_d1, b_d2;
  logic [63:0] q_s[$], q_b[$];
  int n_assert = 0, n_fail = 0;
  int s_vo_cnt = 0, b_vo_cnt = 0, b_fl_cnt = 0, b_kl_cnt = 0;

  always #5 clk = ~clk;

  conv_column_feeder #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(3)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .reuse_kernel(reuse_kernel),
    .kernel_in(kernel_in), .kernel_valid(kernel_valid), .kernel_ready(s_kernel_ready),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(s_pix_ready),
    .conv_data0(s_d0), .conv_data1(s_d1), .conv_data2(s_d2),
    .conv_kernel_load(s_kl), .conv_valid_in(s_vi), .conv_valid_out(s_vo),
    .busy(s_busy), .frame_done(s_fd)
  );
  conv_column_feeder #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .reuse_kernel(reuse_kernel),
    .kernel_in(kernel_in), .kernel_valid(kernel_valid), .kernel_ready(b_kernel_ready),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(b_pix_ready),
    .conv_data0(b_d0), .conv_data1(b_d1), .conv_data2(b_d2),
    .conv_kernel_load(b_kl), .conv_valid_in(b_vi), .conv_valid_out(b_vo),
    .busy(b_busy), .frame_done(b_fd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input bit fd, input bit kl, input bit vo,
                                       input int d0, input int d1, input int d2);
    return {13'd0, fd, kl, vo, 16'(d0), 16'(d1), 16'(d2)};
  endfunction

  function automatic int pv(input int y, input int x);
    return 10 * y + x;
  endfunction

  task automatic push(input bit big, input logic [63:0] b);
    if (big) q_b.push_back(b);
    else q_s.push_back(b);
  endtask

  // every visible beat must match the head of the scoreboard; idle cycles carry no strobes
  always @(negedge clk) if (!rst) begin
    if (s_vi) begin
      check("s_beat", beat(s_fd, s_kl, s_vo, s_d0, s_d1, s_d2), q_s.size() != 0 ? q_s.pop_front() : '1);
      if (s_vo) s_vo_cnt++;
    end else check("s_idle", {61'd0, s_fd, s_kl, s_vo}, 64'd0);
  end

  always @(negedge clk) if (!rst) begin
    if (b_vi) begin
      check("b_beat", beat(b_fd, b_kl, b_vo, b_d0, b_d1, b_d2), q_b.size() != 0 ? q_b.pop_front() : '1);
      if (b_vo) b_vo_cnt++;
      if (b_vo && b_d0 == 16'd0 && b_d1 == 16'd0 && b_d2 == 16'd0) b_fl_cnt++;
      if (b_kl) b_kl_cnt++;
    end else check("b_idle", {61'd0, b_fd, b_kl, b_vo}, 64'd0);
  end

  // entered and left at a negedge
  task automatic send_kernel(input bit big);
    for (int i = 0; i < 9; i++) begin
      int n = 0;
      kernel_in = 16'(i + 1);
      kernel_valid = 1'b1;
      while (!(big ? b_kernel_ready : s_kernel_ready) && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("kernel_ready", {63'd0, big ? b_kernel_ready : s_kernel_ready}, 64'd1);
      @(negedge clk);
    end
    kernel_valid = 1'b0;
    check("kernel_ready_drop", {63'd0, big ? b_kernel_ready : s_kernel_ready}, 64'd0);
    for (int c = 0; c < 3; c++) push(big, beat(1'b0, 1'b1, 1'b0, c + 1, c + 4, c + 7));
  endtask

  task automatic send_frame(input bit big, input int w, input int h, input bit gap, input int npix);
    int k = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        int n = 0;
        if (k == npix) begin
          pix_valid = 1'b0;
          return;
        end
        k++;
        pix_in = 16'(pv(y, x));
        pix_valid = 1'b1;
        while (!(big ? b_pix_ready : s_pix_ready) && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("pix_ready", {63'd0, big ? b_pix_ready : s_pix_ready}, 64'd1);
        if (!(big ? b_pix_ready : s_pix_ready)) begin
          pix_valid = 1'b0;
          return;
        end
        if (y >= 2) push(big, beat(1'b0, 1'b0, x >= 3, pv(y - 2, x), pv(y - 1, x), pv(y, x)));
        if (y >= 2 && x == w - 1) push(big, beat(y == h - 1, 1'b0, 1'b1, 0, 0, 0));
        @(negedge clk);
        if (gap) begin
          pix_valid = 1'b0;
          @(negedge clk);
        end
      end
    pix_valid = 1'b0;
  endtask

  task automatic drain(input bit big);
    for (int i = 0; i < 100 && (big ? q_b.size() : q_s.size()) != 0; i++) @(negedge clk);
    check("drain", 64'(big ? q_b.size() : q_s.size()), 64'd0);
    @(negedge clk);
    check("idle_after_frame", {63'd0, big ? b_busy : s_busy}, 64'd0);
  endtask

  task automatic pulse_start(input bit big, input bit reuse);
    reuse_kernel = reuse;
    if (big) start_b = 1'b1;
    else start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_b = 1'b0;
    reuse_kernel = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s_reset_outs", {9'd0, s_d0, s_d1, s_d2, s_kernel_ready, s_pix_ready, s_kl, s_vi, s_vo, s_busy, s_fd}, 64'd0);
    check("b_reset_outs", {9'd0, b_d0, b_d1, b_d2, b_kernel_ready, b_pix_ready, b_kl, b_vi, b_vo, b_busy, b_fd}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(1'b0, 1'b0);
    check("s_enter_k_rx", {61'd0, s_busy, s_kernel_ready, s_pix_ready}, 64'b110);
    send_kernel(1'b0);
    send_frame(1'b0, 4, 3, 1'b0, 12);
    drain(1'b0);
    pulse_start(1'b0, 1'b1);
    check("s_reuse_to_pix", {61'd0, s_busy, s_kernel_ready, s_pix_ready}, 64'b101);
    send_frame(1'b0, 4, 3, 1'b1, 12);
    drain(1'b0);
    pulse_start(1'b0, 1'b1);
    s_vo_cnt = 0;
    fork
      send_frame(1'b0, 4, 3, 1'b0, 12);
      begin
        repeat (6) @(negedge clk);
        pulse_start(1'b0, 1'b0);
      end
    join
    drain(1'b0);
    check("s_captures_with_stray_start", 64'(s_vo_cnt), 64'd2);
    pulse_start(1'b1, 1'b0);
    send_kernel(1'b1);
    send_frame(1'b1, 28, 28, 1'b0, 784);
    drain(1'b1);
    b_vo_cnt = 0;
    b_fl_cnt = 0;
    b_kl_cnt = 0;
    pulse_start(1'b1, 1'b1);
    send_frame(1'b1, 28, 28, 1'b0, 784);
    drain(1'b1);
    check("b_captures", 64'(b_vo_cnt), 64'd676);
    check("b_flushes", 64'(b_fl_cnt), 64'd26);
    check("b_kernel_beats", 64'(b_kl_cnt), 64'd0);
    pulse_start(1'b1, 1'b1);
    send_frame(1'b1, 28, 28, 1'b0, 5 * 28 + 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("b_rst_mid_outs", {9'd0, b_d0, b_d1, b_d2, b_kernel_ready, b_pix_ready, b_kl, b_vi, b_vo, b_busy, b_fd} & ~64'h0_07FF_FFFF_FFFF_80, 64'd0);
    check("b_rst_mid_strobes", {57'd0, b_kernel_ready, b_pix_ready, b_kl, b_vi, b_vo, b_busy, b_fd}, 64'd0);
    check("b_rst_mid_data", {16'd0, b_d0, b_d1, b_d2}, 64'd0);
    check("b_rst_q_empty", 64'(q_b.size()), 64'd0);
    q_b.delete();
    rst = 1'b0;
    @(negedge clk);
    pulse_start(1'b1, 1'b1);
    check("b_reuse_after_rst_k_rx", {61'd0, b_busy, b_kernel_ready, b_pix_ready}, 64'b110);
    send_kernel(1'b1);
    for (int i = 0; i < 100 && q_b.size() != 0; i++) @(negedge clk);
    check("b_kernel_drain", 64'(q_b.size()), 64'd0);
    check("b_pix_after_kernel", {62'd0, b_kernel_ready, b_pix_ready}, 64'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
